// File: rtl/imem_loader_pkg.sv
// Shared loader definitions: FSM state encoding, stream framing constants
// and the packed-word handoff between the byte packer and the loader.
package imem_loader_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int LEN_BYTES      = 2;
   localparam int INSTR_W        = 32;

   typedef enum logic [2:0] {
      LEN_LO,
      LEN_HI,
      LOAD,
      CHECK,
      DONE,
      ERROR
   } ldr_state_e;

   typedef struct packed {
      logic               vld;
      logic [INSTR_W-1:0] word;
   } packed_word_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles accepted payload bytes into little-endian instruction words and
// emits a one-cycle valid pulse with the full word; the word holds afterwards.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic         clk,
   input  logic         clear_n,
   input  logic         take,
   input  logic [7:0]   in_byte,
   output logic         last_lane,
   output packed_word_t pw
);

   localparam int LW = $clog2(BYTES_PER_WORD);

   logic [LW-1:0]                    lane;
   logic [BYTES_PER_WORD-2:0][7:0]   part;

   assign last_lane = (lane == LW'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         lane <= '0;
         part <= '0;
         pw   <= '0;
      end else begin
         pw.vld <= 1'b0;
         if (take) begin
            if (last_lane) begin
               // Top lane completes the word; lower lanes come from the holding register.
               pw.vld  <= 1'b1;
               pw.word <= {in_byte, part};
               lane    <= '0;
            end else begin
               part[lane] <= in_byte;
               lane       <= lane + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream into instruction memory
// and releases the core from reset only after the XOR checksum matches.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int MAX_WORDS  = 1024
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [INSTR_W-1:0]    mem_wdata,
   output logic                  core_rst_n,
   output logic                  done,
   output logic                  error,
   output logic [15:0]           word_count
);

   ldr_state_e               state, nxt;
   logic [7:0]               len_lo, csum;
   logic [8*LEN_BYTES-1:0]   n_words, n_in;
   logic                     acc, take, last_lane, last_word;
   packed_word_t             pw;

   assign acc       = in_valid && in_ready;
   assign take      = acc && (state == LOAD);
   assign n_in      = {in_data, len_lo};
   assign last_word = ((word_count + 16'd1) == n_words);

   byte_packer u_packer (
      .clk       (clk),
      .clear_n   (rst_n),
      .take      (take),
      .in_byte   (in_data),
      .last_lane (last_lane),
      .pw        (pw)
   );

   assign mem_we    = pw.vld;
   assign mem_wdata = pw.word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= LEN_LO;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         LEN_LO: if (acc) nxt = LEN_HI;
         LEN_HI: if (acc) begin
            if (32'(n_in) > MAX_WORDS) nxt = ERROR;
            else if (n_in == '0)       nxt = CHECK;
            else                       nxt = LOAD;
         end
         LOAD:   if (take && last_lane && last_word) nxt = CHECK;
         CHECK:  if (acc) nxt = (in_data == csum) ? DONE : ERROR;
         default: nxt = state;
      endcase
   end

   // Status outputs are registered from the next state so they move together
   // with the state register and stay low throughout reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_lo     <= '0;
         n_words    <= '0;
         csum       <= '0;
         in_ready   <= 1'b0;
         mem_addr   <= '0;
         word_count <= '0;
         core_rst_n <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         in_ready   <= !(nxt == DONE || nxt == ERROR);
         done       <= (nxt == DONE);
         core_rst_n <= (nxt == DONE);
         error      <= (nxt == ERROR);
         if (acc && state == LEN_LO) len_lo  <= in_data;
         if (acc && state == LEN_HI) n_words <= n_in;
         if (take) csum <= csum ^ in_data;
         if (take && last_lane) begin
            mem_addr   <= ADDR_WIDTH'(word_count);
            word_count <= word_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected memory writes,
// a monitor pops and compares them whenever mem_we is seen.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready, mem_we, core_rst_n, done, error;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [15:0] word_count;

   int n_pass = 0;
   int n_chk  = 0;

   logic [9:0]  exp_addr_q[$];
   logic [31:0] exp_data_q[$];

   int gap_tab[8] = '{0, 2, 5, 0, 1, 0, 3, 0};

   logic [31:0] wn[4] = '{32'h00500013, 32'h00100093, 32'h0, 32'h0};
   logic [31:0] wm[4] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h00000001};

   imem_loader #(.ADDR_WIDTH(10), .MAX_WORDS(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .core_rst_n (core_rst_n),
      .done       (done),
      .error      (error),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every write strobe must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && mem_we) begin
         if (exp_addr_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected write: got addr %h data %h expected none", mem_addr, mem_wdata);
         end else begin
            chk("wr addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
            chk("wr data", mem_wdata, exp_data_q.pop_front());
         end
      end
   end

   task automatic send(input logic [7:0] b, input int gap);
      int t;
      repeat (gap) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = 8'h5A;
      end
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_chk++;
         $display("FAIL send timeout: byte %h got no in_ready expected accept", b);
      end else begin
         @(posedge clk);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic stream(input logic [15:0] len, input int nw, input logic [31:0] w[4],
                         input logic [7:0] ck, input bit thr);
      int g;
      logic [31:0] cur;
      send(len[7:0], 0);
      send(len[15:8], thr ? 1 : 0);
      for (int k = 0; k < nw; k++) begin
         cur = w[k];
         for (int j = 0; j < 4; j++) begin
            g = thr ? gap_tab[(k * 4 + j) % 8] : 0;
            if (j == 3) begin
               exp_addr_q.push_back(10'(k));
               exp_data_q.push_back(cur);
            end
            send(cur[8*j +: 8], g);
         end
      end
      send(ck, thr ? 3 : 0);
      idle();
   endtask

   task automatic check_end(input string tag, input bit e_done, input logic [15:0] e_wc);
      chk({tag, " done"}, 32'(done), 32'(e_done));
      chk({tag, " error"}, 32'(error), 32'(!e_done));
      chk({tag, " core_rst_n"}, 32'(core_rst_n), 32'(e_done));
      chk({tag, " word_count"}, 32'(word_count), 32'(e_wc));
      chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, " pending writes"}, exp_addr_q.size(), 32'd0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
      chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
      chk({tag, " core_rst_n"}, 32'(core_rst_n), 32'd0);
      chk({tag, " done"}, 32'(done), 32'd0);
      chk({tag, " error"}, 32'(error), 32'd0);
      chk({tag, " word_count"}, 32'(word_count), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_zero("por");
      rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready after reset", 32'(in_ready), 32'd1);

      stream(16'd2, 2, wn, 8'hC0, 1'b0);
      check_end("nominal", 1'b1, 16'd2);

      do_reset();
      stream(16'd0, 0, wn, 8'h00, 1'b0);
      check_end("zero len", 1'b1, 16'd0);

      do_reset();
      stream(16'd0, 0, wn, 8'h01, 1'b0);
      check_end("zero len bad ck", 1'b0, 16'd0);

      do_reset();
      send(8'h05, 0);
      send(8'h00, 0);
      idle();
      chk("oversize error", 32'(error), 32'd1);
      chk("oversize in_ready", 32'(in_ready), 32'd0);
      chk("oversize core_rst_n", 32'(core_rst_n), 32'd0);
      repeat (3) @(negedge clk);
      chk("oversize in_ready later", 32'(in_ready), 32'd0);
      chk("oversize word_count", 32'(word_count), 32'd0);

      do_reset();
      stream(16'd2, 2, wn, 8'hC1, 1'b0);
      check_end("bad ck", 1'b0, 16'd2);

      do_reset();
      stream(16'd2, 2, wn, 8'hC0, 1'b1);
      check_end("throttled", 1'b1, 16'd2);

      do_reset();
      stream(16'd4, 4, wm, 8'h23, 1'b0);
      check_end("max len", 1'b1, 16'd4);
      chk("max len last addr", 32'(mem_addr), 32'd3);

      do_reset();
      send(8'h02, 0);
      send(8'h00, 0);
      exp_addr_q.push_back(10'd0);
      exp_data_q.push_back(32'h00500013);
      send(8'h13, 0);
      send(8'h00, 0);
      send(8'h50, 0);
      send(8'h00, 0);
      send(8'h93, 0);
      #2 rst_n = 1'b0;
      #1 check_zero("mid-load reset");
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      stream(16'd2, 2, wn, 8'hC0, 1'b0);
      check_end("reload", 1'b1, 16'd2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader upstream of the single-cycle RISC-V core.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes the words into instruction memory, then releases the core from reset once the payload checksum matches.
- Holds the core in reset for the entire load. On a failed or oversized load, the core is never released.

Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width.
- MAX_WORDS, 1024, largest accepted program length in words; must be <= 2**ADDR_WIDTH.

Ports:
- Clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept a byte.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr  output  ADDR_WIDTH  word address for the write.
- mem_wdata  output  32  instruction word.
- core_rst_n  output  1  active-low reset to the core; low until a successful load.
- done  output  1  load completed and checksum matched (sticky).
- error  output  1  load failed (sticky).
- word_count  output  16  number of words written so far.

Behaviour:
- Reset: asynchronous on rst_n low, dominating everything, including mid-load.
  - State returns to LEN_LO.
  - All outputs reset to 0: in_ready, mem_we, mem_addr, mem_wdata, core_rst_n, done, error, word_count.
  - The assembler byte lane and the checksum clear.
  - in_ready rises in the first cycle after rst_n deasserts.
- Handshake: a byte is accepted on a rising Clk edge where in_valid && in_ready. Back-to-back acceptance every cycle is supported. in_data is ignored when not accepted.
- Stream format:
  - len_lo, len_hi: N = {len_hi, len_lo}.
  - 4*N payload bytes, little-endian per word.
  - 1 checksum byte = XOR of all payload bytes.
- States:
  - LEN_LO: accept byte -> store low length -> LEN_HI.
  - LEN_HI: accept byte -> form N.
    - N > MAX_WORDS -> ERROR.
    - N == 0 -> CHECK.
    - Otherwise -> LOAD.
  - LOAD: accept payload bytes, filling lane 0..3. Every byte is XORed into the checksum.
    - On acceptance of lane 3: next cycle mem_we=1, mem_addr=k, mem_wdata={b3,b2,b1,b0}, where k is the word index starting at 0.
    - word_count increments to k+1 in that same cycle.
    - After the N-th word's lane 3 is accepted -> CHECK.
    - in_ready stays high, so a byte may be accepted in the same cycle mem_we is high.
  - CHECK: accept one byte.
    - Byte equals checksum -> DONE.
    - Otherwise -> ERROR.
  - DONE: in_ready=0, done=1, core_rst_n=1, all registered the cycle after the checksum byte is accepted. Terminal until rst_n.
  - ERROR: in_ready=0, error=1, core_rst_n=0. Terminal until rst_n.
- in_ready = 1 in LEN_LO, LEN_HI, LOAD, CHECK; 0 in DONE and ERROR.
- mem_we: never high outside the cycle after a lane-3 acceptance; never high in DONE or ERROR.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Ranges:
  - N == MAX_WORDS is legal.
  - mem_addr never wraps, because N <= MAX_WORDS <= 2**ADDR_WIDTH.
  - word_count saturates naturally at N.
- Stall tolerance: in_valid gaps of any length are allowed in every state, with no timeout. Partial words stay held in the assembler.

Decomposition:
- Shared package (core-wide) holds:
  - The loader state enum: LEN_LO, LEN_HI, LOAD, CHECK, DONE, ERROR.
  - Constants BYTES_PER_WORD=4 and LEN_BYTES=2.
  - The instruction word width, 32.
- One natural sub-module: byte_packer.
  - Contains the 2-bit lane counter, the 24-bit partial-word register, and the word_valid pulse with the packed 32-bit word.
  - Has a clear input driven from reset.
  - The FSM, address counter and checksum stay in imem_loader.

Test Plan:
- Nominal load: N=2, payload 13 00 50 00 93 00 10 00, checksum 0xC0.
  - Writes addr0=0x00500013 and addr1=0x00100093.
  - word_count=2; done=1 and core_rst_n=1 one cycle after the checksum byte.
- Zero length: stream 00 00 00 -> no mem_we; done=1, core_rst_n=1. With checksum 0x01 instead -> error=1, core_rst_n=0.
- Oversize: MAX_WORDS=4, length bytes 05 00 -> error=1 after LEN_HI; in_ready=0 thereafter; no writes.
- Bad checksum: nominal stream with checksum 0xC1 -> both words written, error=1, done=0, core_rst_n stays 0.
- Throttled source: nominal stream with in_valid toggled randomly, including 5-cycle gaps mid-word -> identical writes and result to back-to-back delivery.
- Reset mid-load: assert rst_n low after 5 payload bytes.
  - All outputs are 0 immediately.
  - After release, a fresh nominal stream reloads from addr 0 and completes with done=1.
